// File: rtl/rca_pipe_if.sv
// Operand/result handshake bundle for rca_pipe.
// The master offers operands and consumes results; the slave is the adder itself.
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk rippled per stage with the inter-chunk carry registered.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic      clk,
  input  logic      rst,
  rca_pipe_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  // Returns {carry into chunk MSB, carry out, CW-bit sum}.
  function automatic logic [CW+1:0] rca_chunk(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y,
    input logic          cin
  );
    logic [CW:0]   c;
    logic [CW-1:0] s;
    c[0] = cin;
    for (int i = 0; i < CW; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[CW-1], c[CW], s};
  endfunction

  logic             r_vld   [STAGES];
  logic             r_carry [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_ovf;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [CW+1:0]    w_res   [STAGES];
  logic [WIDTH-1:0] w_sum   [STAGES];
  logic             w_carry [STAGES];
  logic             w_ovf;
  logic             w_unused;

  assign w_adv = !r_vld[STAGES-1] || bus.out_ready;

  // Per-stage chunk ripple; each stage merges its chunk into the partial sum it received.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_res[k]   = {(CW+2){1'b0}};
      w_sum[k]   = {WIDTH{1'b0}};
      w_carry[k] = 1'b0;
    end
    w_b_eff = bus.sub ? ~bus.b : bus.b;
    w_c0    = bus.sub ? 1'b1 : bus.carry_in;

    w_res[0]            = rca_chunk(bus.a[CW-1:0], w_b_eff[CW-1:0], w_c0);
    w_sum[0][CW-1:0]    = w_res[0][CW-1:0];
    w_carry[0]          = w_res[0][CW];

    for (int k = 1; k < STAGES; k++) begin
      w_res[k]             = rca_chunk(r_a[k-1][k*CW +: CW], r_b[k-1][k*CW +: CW], r_carry[k-1]);
      w_sum[k]             = r_sum[k-1];
      w_sum[k][k*CW +: CW] = w_res[k][CW-1:0];
      w_carry[k]           = w_res[k][CW];
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    w_ovf = w_res[STAGES-1][CW+1] ^ w_res[STAGES-1][CW];
  end

  // Pipeline registers: the whole pipe advances together or holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]   <= 1'b0;
        r_carry[k] <= 1'b0;
        r_sum[k]   <= {WIDTH{1'b0}};
        r_a[k]     <= {WIDTH{1'b0}};
        r_b[k]     <= {WIDTH{1'b0}};
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_vld[0]   <= bus.in_valid;
      r_a[0]     <= bus.a;
      r_b[0]     <= w_b_eff;
      r_sum[0]   <= w_sum[0];
      r_carry[0] <= w_carry[0];
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k]   <= r_vld[k-1];
        r_a[k]     <= r_a[k-1];
        r_b[k]     <= r_b[k-1];
        r_sum[k]   <= w_sum[k];
        r_carry[k] <= w_carry[k];
      end
      r_ovf <= w_ovf;
    end
  end

  // Last-stage operand copies have no consumer.
  assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1]};

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.carry_out = r_carry[STAGES-1];
  assign bus.overflow  = r_ovf;
endmodule
